// File: rtl/simple_aes_axi_slave_if.sv
// AXI4-Lite bus bundle between the block-design master and the simple AES register slave.
interface simple_aes_axi_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/simple_aes_axi_slave.sv
// AXI4-Lite register slave for the simple AES core: key/plaintext registers,
// start pulse, busy/done status and captured ciphertext.
module simple_aes_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  simple_aes_axi_slave_if.slave  s_axi,
  output logic [127:0]           aes_key,
  output logic [127:0]           aes_din,
  output logic                   aes_start,
  input  logic [127:0]           aes_dout,
  input  logic                   aes_done
);
  typedef logic [C_S_AXI_DATA_WIDTH-1:0]   word_t;
  typedef logic [C_S_AXI_DATA_WIDTH/8-1:0] strb_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic  awready_q, awready_d;
  logic  bvalid_q,  bvalid_d;
  logic  [1:0] bresp_q, bresp_d;
  logic  arready_q, arready_d;
  logic  rvalid_q,  rvalid_d;
  word_t rdata_q,   rdata_d;
  logic  busy_q,    busy_d;
  logic  done_q,    done_d;
  logic  start_q,   start_d;
  word_t key_q [4];
  word_t key_d [4];
  word_t din_q [4];
  word_t din_d [4];
  word_t dout_q [4];
  word_t dout_d [4];

  logic  wr_fire, rd_fire;
  logic  [C_S_AXI_ADDR_WIDTH-3:0] wr_idx, rd_idx;
  word_t wdata;
  strb_t wstrb;
  logic  unused_ok;

  assign wr_fire = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_fire = arready_q & s_axi.S_AXI_ARVALID;
  assign wr_idx  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wdata   = s_axi.S_AXI_WDATA;
  assign wstrb   = s_axi.S_AXI_WSTRB;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w, input strb_t strb);
    word_t res;
    res = old_w;
    for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Write path: address and data are only taken together, one transfer in flight.
  always_comb begin
    awready_d = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q & ~awready_q;
    bvalid_d  = bvalid_q & ~s_axi.S_AXI_BREADY;
    bresp_d   = bresp_q;
    busy_d    = busy_q;
    done_d    = done_q;
    start_d   = 1'b0;
    key_d     = key_q;
    din_d     = din_q;
    dout_d    = dout_q;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (wr_idx)
        4'h0: if (wstrb[0] && wdata[0] && !busy_q) start_d = 1'b1;
        4'h1: if (wstrb[0] && wdata[1]) done_d = 1'b0;
        4'h4, 4'h5, 4'h6, 4'h7:
          key_d[wr_idx[1:0]] = merge_bytes(key_q[wr_idx[1:0]], wdata, wstrb);
        4'h8, 4'h9, 4'hA, 4'hB:
          din_d[wr_idx[1:0]] = merge_bytes(din_q[wr_idx[1:0]], wdata, wstrb);
        4'hC, 4'hD, 4'hE, 4'hF: bresp_d = RESP_SLVERR;
        default: ;
      endcase
    end
    // Completion beats a same-cycle W1C; a same-cycle new launch beats completion.
    if (aes_done) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      for (int i = 0; i < 4; i++) dout_d[i] = aes_dout[32*i +: 32];
    end
    if (start_d) begin
      busy_d = 1'b1;
      done_d = 1'b0;
    end
  end

  always_comb begin
    arready_d = s_axi.S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d  = rvalid_q & ~s_axi.S_AXI_RREADY;
    rdata_d   = rdata_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      case (rd_idx)
        4'h1:                   rdata_d = word_t'({done_q, busy_q});
        4'h4, 4'h5, 4'h6, 4'h7: rdata_d = key_q[rd_idx[1:0]];
        4'h8, 4'h9, 4'hA, 4'hB: rdata_d = din_q[rd_idx[1:0]];
        4'hC, 4'hD, 4'hE, 4'hF: rdata_d = dout_q[rd_idx[1:0]];
        default:                rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        key_q[i]  <= '0;
        din_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
      for (int i = 0; i < 4; i++) begin
        key_q[i]  <= key_d[i];
        din_q[i]  <= din_d[i];
        dout_q[i] <= dout_d[i];
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = RESP_OKAY;
  assign aes_start           = start_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign aes_key[32*gi +: 32] = key_q[gi];
    assign aes_din[32*gi +: 32] = din_q[gi];
  end
endmodule

// File: tb/tb_simple_aes_axi_slave.sv
// Directed bench for simple_aes_axi_slave: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them as the slave presents them.
module tb_simple_aes_axi_slave;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] aes_key, aes_din, aes_dout;
  logic         aes_start, aes_done;

  simple_aes_axi_slave_if axi();

  simple_aes_axi_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (axi),
    .aes_key       (aes_key),
    .aes_din       (aes_din),
    .aes_start     (aes_start),
    .aes_dout      (aes_dout),
    .aes_done      (aes_done)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [127:0] CT1 = 128'h3925841D_02DC09FB_DC118597_196A0B32;
  localparam logic [127:0] CT2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] CT3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  int n_vec = 0;
  int n_err = 0;
  int start_hi = 0;
  logic [1:0]  b_exp_q [$];
  logic [31:0] r_exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  initial begin
    logic [1:0]  eb;
    logic [31:0] er;
    forever begin
      @(negedge clk);
      if (rst_n && axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
        if (r_exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL r_unexpected: got rdata %0h, expected no response", axi.S_AXI_RDATA);
        end else begin
          er = r_exp_q.pop_front();
          $display("R rdata=%08h rresp=%0d exp=%08h", axi.S_AXI_RDATA, axi.S_AXI_RRESP, er);
          check("r_data", {axi.S_AXI_RRESP, axi.S_AXI_RDATA}, {OKAY, er});
        end
      end
      if (rst_n && axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
        if (b_exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_unexpected: got bresp %0d, expected no response", axi.S_AXI_BRESP);
        end else begin
          eb = b_exp_q.pop_front();
          $display("B bresp=%0d exp=%0d", axi.S_AXI_BRESP, eb);
          check("b_resp", axi.S_AXI_BRESP, eb);
        end
      end
    end
  end

  always @(negedge clk) if (aes_start === 1'b1) start_hi++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic aw_phase(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    axi.S_AXI_AWADDR = a; axi.S_AXI_WDATA = d; axi.S_AXI_WSTRB = s;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    while (!axi.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
    if (!axi.S_AXI_AWREADY) begin
      n_vec++; n_err++;
      $display("FAIL aw_timeout: got no AWREADY, expected within 20 cycles");
    end else check("wready_with_awready", axi.S_AXI_WREADY, 1'b1);
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
  endtask

  task automatic ar_phase(input logic [5:0] a);
    int n = 0;
    @(posedge clk); #1;
    axi.S_AXI_ARADDR = a; axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    while (!axi.S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
    if (!axi.S_AXI_ARREADY) begin
      n_vec++; n_err++;
      $display("FAIL ar_timeout: got no ARREADY, expected within 20 cycles");
    end
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp);
    b_exp_q.push_back(resp);
    aw_phase(a, d, s);
    @(negedge clk);
    check("b_latency", axi.S_AXI_BVALID, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] exp);
    r_exp_q.push_back(exp);
    ar_phase(a);
    @(negedge clk);
    check("r_latency", axi.S_AXI_RVALID, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_done(input logic [127:0] ct);
    @(posedge clk); #1;
    aes_dout = ct; aes_done = 1'b1;
    @(posedge clk); #1;
    aes_done = 1'b0;
  endtask

  initial begin
    int n_aw, n_ar, n;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0;  axi.S_AXI_WSTRB = '0;  axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b1;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b1;
    aes_dout = '0; aes_done = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b000);
    check("rst_valid", {axi.S_AXI_BVALID, axi.S_AXI_RVALID, aes_start}, 3'b000);
    check("rst_resp_data", {axi.S_AXI_BRESP, axi.S_AXI_RRESP, axi.S_AXI_RDATA}, 36'h0);
    check("rst_key_din", {aes_key, aes_din} == 256'h0, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) axi_read(6'(i * 4), 32'h0);

    // Key/plaintext registers
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(16 + 4 * i), 32'(i + 1), 4'hF, OKAY);
      axi_write(6'(32 + 4 * i), 32'h11111111 * 32'(i + 1), 4'hF, OKAY);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(16 + 4 * i), 32'(i + 1));
      axi_read(6'(32 + 4 * i), 32'h11111111 * 32'(i + 1));
    end
    check("aes_key", aes_key, 128'h00000004_00000003_00000002_00000001);
    check("aes_din", aes_din, 128'h44444444_33333333_22222222_11111111);

    // Start, ignored restart, completion
    axi_write(6'h00, 32'h1, 4'hF, OKAY);
    repeat (2) @(negedge clk);
    check("start_width", start_hi, 1);
    axi_read(6'h04, 32'h1);
    axi_write(6'h00, 32'h1, 4'hF, OKAY);
    repeat (2) @(negedge clk);
    check("start_ignored_busy", start_hi, 1);
    repeat (8) @(posedge clk);
    pulse_done(CT1);
    axi_read(6'h04, 32'h2);
    axi_read(6'h30, 32'h196A0B32);
    axi_read(6'h34, 32'hDC118597);
    axi_read(6'h38, 32'h02DC09FB);
    axi_read(6'h3C, 32'h3925841D);

    // Strobes, read-only DOUT, reserved, ignored low address bits
    axi_write(6'h14, 32'hAABBCCDD, 4'b0101, OKAY);
    axi_read(6'h14, 32'h00BB00DD);
    axi_write(6'h30, 32'hDEADBEEF, 4'hF, SLVERR);
    axi_read(6'h30, 32'h196A0B32);
    axi_write(6'h08, 32'hFFFFFFFF, 4'hF, OKAY);
    axi_read(6'h08, 32'h0);
    axi_read(6'h13, 32'h1);

    // Back-pressure on B and R with a second transfer waiting
    axi.S_AXI_BREADY = 1'b0; axi.S_AXI_RREADY = 1'b0;
    b_exp_q.push_back(OKAY);
    aw_phase(6'h18, 32'h12345678, 4'hF);
    r_exp_q.push_back(32'h1);
    ar_phase(6'h10);
    b_exp_q.push_back(OKAY);
    r_exp_q.push_back(32'h00BB00DD);
    axi.S_AXI_AWADDR = 6'h1C; axi.S_AXI_WDATA = 32'h55; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_ARADDR = 6'h14; axi.S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_b", {axi.S_AXI_BVALID, axi.S_AXI_BRESP}, {1'b1, OKAY});
      check("stall_r", {axi.S_AXI_RVALID, axi.S_AXI_RDATA}, {1'b1, 32'h1});
      check("stall_no_accept", {axi.S_AXI_AWREADY, axi.S_AXI_ARREADY}, 2'b00);
    end
    @(posedge clk); #1;
    axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b1;
    n_aw = 0; n_ar = 0;
    fork
      begin
        @(negedge clk);
        while (!axi.S_AXI_AWREADY && n_aw < 20) begin @(negedge clk); n_aw++; end
        check("post_stall_aw", axi.S_AXI_AWREADY, 1'b1);
        @(posedge clk); #1;
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
      end
      begin
        @(negedge clk);
        while (!axi.S_AXI_ARREADY && n_ar < 20) begin @(negedge clk); n_ar++; end
        check("post_stall_ar", axi.S_AXI_ARREADY, 1'b1);
        @(posedge clk); #1;
        axi.S_AXI_ARVALID = 1'b0;
      end
    join
    repeat (3) @(posedge clk); #1;
    axi_read(6'h18, 32'h12345678);
    axi_read(6'h1C, 32'h55);

    // AW without W is never taken
    axi.S_AXI_AWADDR = 6'h1C; axi.S_AXI_WDATA = 32'hFFFFFFFF; axi.S_AXI_AWVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("aw_alone", {axi.S_AXI_AWREADY, axi.S_AXI_BVALID}, 2'b00);
    end
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0;
    axi_read(6'h1C, 32'h55);

    // DONE W1C, then W1C racing a completion
    axi_write(6'h04, 32'h2, 4'h1, OKAY);
    axi_read(6'h04, 32'h0);
    b_exp_q.push_back(OKAY);
    @(posedge clk); #1;
    axi.S_AXI_AWADDR = 6'h04; axi.S_AXI_WDATA = 32'h2; axi.S_AXI_WSTRB = 4'h1;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.S_AXI_AWREADY && n < 20) begin @(negedge clk); n++; end
    check("race_aw", axi.S_AXI_AWREADY, 1'b1);
    aes_dout = CT2; aes_done = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; aes_done = 1'b0;
    @(posedge clk); #1;
    axi_read(6'h04, 32'h2);
    axi_read(6'h30, 32'h76543210);

    // Reset with an operation running and BVALID pending
    axi_write(6'h00, 32'h1, 4'h1, OKAY);
    axi.S_AXI_BREADY = 1'b0;
    aw_phase(6'h10, 32'hFFFF0000, 4'hF);
    @(negedge clk);
    check("pre_rst_bvalid", axi.S_AXI_BVALID, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bvalid", axi.S_AXI_BVALID, 1'b0);
    check("async_rst_key", aes_key, 128'h0);
    check("async_rst_din", aes_din, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    axi.S_AXI_BREADY = 1'b1;
    axi_read(6'h04, 32'h0);
    axi_read(6'h10, 32'h0);
    axi_read(6'h3C, 32'h0);
    pulse_done(CT3);
    axi_read(6'h04, 32'h2);
    axi_read(6'h30, 32'hF0F0F0F0);

    n = 0;
    while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && n < 50) begin @(negedge clk); n++; end
    check("scoreboard_empty", b_exp_q.size() + r_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
